serial_fifo_ctrl: RTL and testbench
===================================

Name: serial_fifo_ctrl

Overview:
Pointer and flag controller for the serial block's register-file FIFO. It arbitrates write (RX/APB push) and read (TX/APB pop) requests, generates the write and read addresses for the storage array, and tracks occupancy, full/empty/almost-full flags and sticky overflow/underflow errors. It replaces the separate read/write counters with a single controller, so the flags and pointers can never disagree.

Parameters:
DEPTH, 8, number of FIFO entries; 2 <= DEPTH <= 2^ADDR_SIZE.
ADDR_SIZE, 3, pointer width.
AF_THRESH, 6, almost_full asserts when count >= AF_THRESH; 1 <= AF_THRESH <= DEPTH.

Ports:
clk  in  1  clock, rising edge
n_rst  in  1  asynchronous active-low reset
wr_req  in  1  push request, one entry per cycle
rd_req  in  1  pop request, one entry per cycle
flush  in  1  synchronous clear of pointers and count
clr_err  in  1  clears the sticky overflow/underflow flags
wr_en  out  1  storage write strobe; combinational, = accepted push this cycle
wptr  out  ADDR_SIZE  storage write address (registered)
rptr  out  ADDR_SIZE  storage read address, head entry (registered)
rd_ack  out  1  registered pulse, one cycle after an accepted pop
count  out  ADDR_SIZE+1  occupancy, 0..DEPTH
empty  out  1  count == 0
full  out  1  count == DEPTH
almost_full  out  1  count >= AF_THRESH
overflow  out  1  sticky: push attempted while full
underflow  out  1  sticky: pop attempted while empty

Behaviour:
- Reset (n_rst low, async): wptr=0, rptr=0, count=0, rd_ack=0, overflow=0, underflow=0, empty=1, full=0, almost_full=0. Both pointers start at 0; rptr always addresses the oldest valid entry.
- State (registered, one-hot or encoded): EMPTY, PARTIAL, FULL. empty/full/almost_full are registered and derived from next_count, so they are valid in the same cycle as count.
- Acceptance: push_ok = wr_req & ~full & ~flush. pop_ok = rd_req & ~empty & ~flush. Flags are evaluated on the current registered state only. Pop-frees-slot-same-cycle is not supported: a push while full is rejected even if a pop is accepted that cycle.
- Pointer advance: on push_ok, wptr increments; on pop_ok, rptr increments. Each pointer wraps from DEPTH-1 to 0 explicitly; no reliance on binary overflow unless DEPTH = 2^ADDR_SIZE.
- count: +1 on push only, -1 on pop only, unchanged on both or neither. count never leaves the range 0..DEPTH.
- Transitions:
  - EMPTY -> PARTIAL on push (DEPTH > 1).
  - PARTIAL -> FULL when count reaches DEPTH.
  - PARTIAL -> EMPTY when count reaches 0.
  - FULL -> PARTIAL on pop.
  - Any state -> EMPTY on flush.
- rd_ack: 1 in the cycle after pop_ok, else 0. Storage data at the old rptr is sampled by the consumer in that cycle; the storage array must hold its read data for one cycle.
- wr_en equals push_ok combinationally; the array writes at the current wptr on the same edge the pointer advances.
- Errors: overflow sets on wr_req & full & ~flush. underflow sets on rd_req & empty & ~flush. Both hold until clr_err. If clr_err and a new error occur in the same cycle, set wins. flush does not clear the error flags.
- flush: highest priority after reset. Next cycle: wptr=rptr=0, count=0, empty=1, rd_ack=0. Requests in the flush cycle are ignored and raise no errors.
- Reset mid-operation: all state returns to reset values immediately; no partial pointer updates survive.

Test Plan:
1. Reset, then 8 pushes, no pops -> wptr 0..7 then wraps to 0; count=8; full=1 after the 8th edge; almost_full=1 from count=6; state FULL.
2. From full, push + pop in the same cycle -> push rejected, overflow=1, pop accepted, count=7, rptr=1; rd_ack=1 on the next cycle.
3. Pop 8 times from full -> rptr wraps 7->0, count=0, empty=1. A 9th pop -> underflow=1, rptr stays 0, rd_ack stays 0.
4. Steady state at count=3: push+pop together for 10 cycles -> count holds at 3; wptr and rptr each advance by 10 mod 8; no flag changes.
5. count=5, then flush with wr_req=rd_req=1 -> next cycle pointers=0, count=0, empty=1, no new error bits; a pre-set overflow stays 1 until clr_err.
6. DEPTH=5, ADDR_SIZE=3: 7 pushes interleaved with pops -> pointers wrap at 4->0, never reach 5..7; n_rst dropped mid-burst returns all outputs to reset values asynchronously.

Source files
------------

// File: rtl/serial_fifo_ctrl.sv
// serial_fifo_ctrl: single pointer/flag controller for the serial block's
// register-file FIFO. Owns write/read addresses, occupancy, fill flags and
// sticky overflow/underflow errors so that flags and pointers cannot disagree.
module serial_fifo_ctrl #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned ADDR_SIZE = 3,
    parameter int unsigned AF_THRESH = 6
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 wr_req,
    input  logic                 rd_req,
    input  logic                 flush,
    input  logic                 clr_err,
    output logic                 wr_en,
    output logic [ADDR_SIZE-1:0] wptr,
    output logic [ADDR_SIZE-1:0] rptr,
    output logic                 rd_ack,
    output logic [ADDR_SIZE:0]   count,
    output logic                 empty,
    output logic                 full,
    output logic                 almost_full,
    output logic                 overflow,
    output logic                 underflow
);

    typedef enum logic [1:0] {
        StEmpty   = 2'd0,
        StPartial = 2'd1,
        StFull    = 2'd2
    } state_e;

    // Pointers wrap explicitly at DEPTH-1 so non-power-of-two depths work.
    localparam logic [ADDR_SIZE-1:0] LastAddr = ADDR_SIZE'(DEPTH - 1);
    localparam logic [ADDR_SIZE:0]   DepthCnt = (ADDR_SIZE + 1)'(DEPTH);
    localparam logic [ADDR_SIZE:0]   AfCnt    = (ADDR_SIZE + 1)'(AF_THRESH);

    state_e                 state_q, state_d;
    logic [ADDR_SIZE-1:0]   wptr_q, wptr_d;
    logic [ADDR_SIZE-1:0]   rptr_q, rptr_d;
    logic [ADDR_SIZE:0]     count_q, count_d;
    logic                   af_q, af_d;
    logic                   rd_ack_q;
    logic                   ovf_q, ovf_d;
    logic                   unf_q, unf_d;
    logic                   full_w, empty_w;
    logic                   push_ok, pop_ok;

    // Flags come straight from the registered state, so they line up with count.
    assign empty_w = (state_q == StEmpty);
    assign full_w  = (state_q == StFull);

    // Request acceptance, pointer advance and occupancy update.
    always_comb begin
        push_ok = wr_req & ~full_w & ~flush;
        pop_ok  = rd_req & ~empty_w & ~flush;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push_ok) begin
                wptr_d = (wptr_q == LastAddr) ? '0 : wptr_q + ADDR_SIZE'(1);
            end
            if (pop_ok) begin
                rptr_d = (rptr_q == LastAddr) ? '0 : rptr_q + ADDR_SIZE'(1);
            end
            // Simultaneous push and pop leaves occupancy unchanged.
            if (push_ok && !pop_ok) begin
                count_d = count_q + (ADDR_SIZE + 1)'(1);
            end else if (pop_ok && !push_ok) begin
                count_d = count_q - (ADDR_SIZE + 1)'(1);
            end
        end
    end

    // Fill-state transitions, decided from the next occupancy.
    always_comb begin
        state_d = state_q;
        af_d    = (count_d >= AfCnt);
        if (flush) begin
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (count_d != '0) begin
                        state_d = (count_d == DepthCnt) ? StFull : StPartial;
                    end
                end
                StPartial: begin
                    if (count_d == DepthCnt) begin
                        state_d = StFull;
                    end else if (count_d == '0) begin
                        state_d = StEmpty;
                    end
                end
                StFull: begin
                    if (count_d != DepthCnt) begin
                        state_d = StPartial;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    // Sticky errors: a new error in the clearing cycle wins over clr_err.
    always_comb begin
        ovf_d = (ovf_q & ~clr_err) | (wr_req & full_w & ~flush);
        unf_d = (unf_q & ~clr_err) | (rd_req & empty_w & ~flush);
    end

    // Controller state register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= StEmpty;
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            af_q     <= 1'b0;
            rd_ack_q <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            af_q     <= af_d;
            rd_ack_q <= pop_ok;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    assign wr_en       = push_ok;
    assign wptr        = wptr_q;
    assign rptr        = rptr_q;
    assign rd_ack      = rd_ack_q;
    assign count       = count_q;
    assign empty       = empty_w;
    assign full        = full_w;
    assign almost_full = af_q;
    assign overflow    = ovf_q;
    assign underflow   = unf_q;

endmodule

// File: tb/tb_serial_fifo_ctrl.sv
// Bench for serial_fifo_ctrl: an 8-deep and a 5-deep instance share stimulus;
// a queue-free occupancy model (counts and modular pointers) predicts both.
module tb_serial_fifo_ctrl;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       wr_req, rd_req, flush, clr_err;
    logic       wr_en_s  [2];
    logic [2:0] wptr_s   [2];
    logic [2:0] rptr_s   [2];
    logic       rd_ack_s [2];
    logic [3:0] count_s  [2];
    logic       empty_s  [2];
    logic       full_s   [2];
    logic       af_s     [2];
    logic       ovf_s    [2];
    logic       unf_s    [2];

    int n_vec = 0;
    int n_err = 0;

    // Reference model state per instance.
    int m_cnt [2];
    int m_wp  [2];
    int m_rp  [2];
    bit m_ack [2];
    bit m_ovf [2];
    bit m_unf [2];

    localparam logic [15:0] RstVec = 16'h0020;

    always #5 clk = ~clk;

    serial_fifo_ctrl #(.DEPTH(8), .ADDR_SIZE(3), .AF_THRESH(6)) dut8 (
        .clk(clk), .n_rst(n_rst), .wr_req(wr_req), .rd_req(rd_req), .flush(flush),
        .clr_err(clr_err), .wr_en(wr_en_s[0]), .wptr(wptr_s[0]), .rptr(rptr_s[0]),
        .rd_ack(rd_ack_s[0]), .count(count_s[0]), .empty(empty_s[0]), .full(full_s[0]),
        .almost_full(af_s[0]), .overflow(ovf_s[0]), .underflow(unf_s[0])
    );

    serial_fifo_ctrl #(.DEPTH(5), .ADDR_SIZE(3), .AF_THRESH(4)) dut5 (
        .clk(clk), .n_rst(n_rst), .wr_req(wr_req), .rd_req(rd_req), .flush(flush),
        .clr_err(clr_err), .wr_en(wr_en_s[1]), .wptr(wptr_s[1]), .rptr(rptr_s[1]),
        .rd_ack(rd_ack_s[1]), .count(count_s[1]), .empty(empty_s[1]), .full(full_s[1]),
        .almost_full(af_s[1]), .overflow(ovf_s[1]), .underflow(unf_s[1])
    );

    function automatic int dep(int i);
        return (i == 0) ? 8 : 5;
    endfunction

    function automatic int afth(int i);
        return (i == 0) ? 6 : 4;
    endfunction

    function automatic bit m_push(int i, bit wr, bit fl);
        return wr && (m_cnt[i] != dep(i)) && !fl;
    endfunction

    function automatic bit m_pop(int i, bit rd, bit fl);
        return rd && (m_cnt[i] != 0) && !fl;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0; m_wp[i] = 0; m_rp[i] = 0;
            m_ack[i] = 0; m_ovf[i] = 0; m_unf[i] = 0;
        end
    endfunction

    function automatic void model_step(bit wr, bit rd, bit fl, bit clr);
        for (int i = 0; i < 2; i++) begin
            bit pu;
            bit po;
            pu = m_push(i, wr, fl);
            po = m_pop(i, rd, fl);
            m_ovf[i] = (m_ovf[i] && !clr) || (wr && m_cnt[i] == dep(i) && !fl);
            m_unf[i] = (m_unf[i] && !clr) || (rd && m_cnt[i] == 0 && !fl);
            m_ack[i] = po;
            if (fl) begin
                m_cnt[i] = 0; m_wp[i] = 0; m_rp[i] = 0;
            end else begin
                m_cnt[i] = m_cnt[i] + int'(pu) - int'(po);
                m_wp[i]  = (m_wp[i] + int'(pu)) % dep(i);
                m_rp[i]  = (m_rp[i] + int'(po)) % dep(i);
            end
        end
    endfunction

    function automatic logic [15:0] got_vec(int i);
        return {count_s[i], wptr_s[i], rptr_s[i], empty_s[i], full_s[i], af_s[i],
                ovf_s[i], unf_s[i], rd_ack_s[i]};
    endfunction

    function automatic logic [15:0] exp_vec(int i);
        return {4'(m_cnt[i]), 3'(m_wp[i]), 3'(m_rp[i]), m_cnt[i] == 0, m_cnt[i] == dep(i),
                m_cnt[i] >= afth(i), m_ovf[i], m_unf[i], m_ack[i]};
    endfunction

    // One clock with the given requests; the model follows the same edge.
    task automatic cycle(input bit wr, input bit rd, input bit fl, input bit clr);
        wr_req = wr; rd_req = rd; flush = fl; clr_err = clr;
        @(posedge clk);
        model_step(wr, rd, fl, clr);
        #1;
        wr_req = 0; rd_req = 0; flush = 0; clr_err = 0;
    endtask

    task automatic test_reset();
        n_rst = 0; wr_req = 0; rd_req = 0; flush = 0; clr_err = 0;
        model_reset();
        #3;
        for (int i = 0; i < 2; i++) begin
            n_vec++;
            if (got_vec(i) !== RstVec) begin
                n_err++;
                $display("FAIL reset[%0d]: got %h want %h", i, got_vec(i), RstVec);
            end
        end
        #9 n_rst = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_fill();
        for (int k = 0; k < 8; k++) begin
            cycle(1, 0, 0, 0);
            n_vec++;
            if (wptr_s[0] !== 3'((k + 1) % 8) || count_s[0] !== 4'(k + 1)
                || af_s[0] !== logic'(k + 1 >= 6)) begin
                n_err++;
                $display("FAIL fill[%0d]: got wptr=%0d cnt=%0d af=%b", k, wptr_s[0],
                         count_s[0], af_s[0]);
            end
        end
        n_vec++;
        if (full_s[0] !== 1'b1 || empty_s[0] !== 1'b0) begin
            n_err++;
            $display("FAIL fill_flags: got full=%b empty=%b want 1 0", full_s[0], empty_s[0]);
        end
    endtask

    task automatic test_push_pop_full();
        cycle(1, 1, 0, 0);
        n_vec++;
        if (count_s[0] !== 4'd7 || rptr_s[0] !== 3'd1 || wptr_s[0] !== 3'd0
            || ovf_s[0] !== 1'b1 || rd_ack_s[0] !== 1'b1) begin
            n_err++;
            $display("FAIL push_pop_full: got cnt=%0d rptr=%0d wptr=%0d ovf=%b ack=%b",
                     count_s[0], rptr_s[0], wptr_s[0], ovf_s[0], rd_ack_s[0]);
        end
        cycle(0, 0, 0, 0);
        n_vec++;
        if (rd_ack_s[0] !== 1'b0) begin
            n_err++;
            $display("FAIL ack_pulse: got %b want 0", rd_ack_s[0]);
        end
    endtask

    task automatic test_drain();
        for (int k = 0; k < 7; k++) cycle(0, 1, 0, 0);
        n_vec++;
        if (rptr_s[0] !== 3'd0 || count_s[0] !== 4'd0 || empty_s[0] !== 1'b1) begin
            n_err++;
            $display("FAIL drain: got rptr=%0d cnt=%0d empty=%b want 0 0 1", rptr_s[0],
                     count_s[0], empty_s[0]);
        end
        cycle(0, 1, 0, 0);
        n_vec++;
        if (unf_s[0] !== 1'b1 || rptr_s[0] !== 3'd0 || rd_ack_s[0] !== 1'b0) begin
            n_err++;
            $display("FAIL underflow: got unf=%b rptr=%0d ack=%b want 1 0 0", unf_s[0],
                     rptr_s[0], rd_ack_s[0]);
        end
    endtask

    task automatic test_back_to_back();
        cycle(0, 0, 0, 1);
        n_vec++;
        if (ovf_s[0] !== 1'b0 || unf_s[0] !== 1'b0) begin
            n_err++;
            $display("FAIL clr_err: got ovf=%b unf=%b want 0 0", ovf_s[0], unf_s[0]);
        end
        for (int k = 0; k < 3; k++) cycle(1, 0, 0, 0);
        for (int k = 0; k < 10; k++) begin
            cycle(1, 1, 0, 0);
            n_vec++;
            if (count_s[0] !== 4'd3 || empty_s[0] !== 1'b0 || full_s[0] !== 1'b0
                || af_s[0] !== 1'b0) begin
                n_err++;
                $display("FAIL steady[%0d]: got cnt=%0d e=%b f=%b af=%b", k, count_s[0],
                         empty_s[0], full_s[0], af_s[0]);
            end
        end
        n_vec++;
        if (wptr_s[0] !== 3'd5 || rptr_s[0] !== 3'd2) begin
            n_err++;
            $display("FAIL steady_ptrs: got wptr=%0d rptr=%0d want 5 2", wptr_s[0], rptr_s[0]);
        end
    endtask

    task automatic test_flush();
        for (int k = 0; k < 5; k++) cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        for (int k = 0; k < 3; k++) cycle(0, 1, 0, 0);
        n_vec++;
        if (count_s[0] !== 4'd5 || ovf_s[0] !== 1'b1) begin
            n_err++;
            $display("FAIL pre_flush: got cnt=%0d ovf=%b want 5 1", count_s[0], ovf_s[0]);
        end
        cycle(1, 1, 1, 0);
        n_vec++;
        if (wptr_s[0] !== 3'd0 || rptr_s[0] !== 3'd0 || count_s[0] !== 4'd0
            || empty_s[0] !== 1'b1 || ovf_s[0] !== 1'b1 || unf_s[0] !== 1'b0
            || rd_ack_s[0] !== 1'b0) begin
            n_err++;
            $display("FAIL flush: got %h", got_vec(0));
        end
        cycle(0, 1, 0, 1);
        n_vec++;
        if (ovf_s[0] !== 1'b0 || unf_s[0] !== 1'b1) begin
            n_err++;
            $display("FAIL clr_vs_set: got ovf=%b unf=%b want 0 1", ovf_s[0], unf_s[0]);
        end
        cycle(0, 0, 0, 1);
        n_vec++;
        if (unf_s[0] !== 1'b0) begin
            n_err++;
            $display("FAIL clr_unf: got %b want 0", unf_s[0]);
        end
    endtask

    task automatic test_wrap5();
        cycle(0, 0, 1, 0);
        for (int k = 0; k < 7; k++) begin
            cycle(1, (k % 2) == 1, 0, 0);
            n_vec++;
            if (wptr_s[1] !== 3'(m_wp[1]) || rptr_s[1] !== 3'(m_rp[1])
                || wptr_s[1] > 3'd4 || rptr_s[1] > 3'd4) begin
                n_err++;
                $display("FAIL wrap5[%0d]: got wptr=%0d rptr=%0d want %0d %0d", k, wptr_s[1],
                         rptr_s[1], m_wp[1], m_rp[1]);
            end
        end
        n_vec++;
        if (wptr_s[1] !== 3'd2 || rptr_s[1] !== 3'd3 || count_s[1] !== 4'd4) begin
            n_err++;
            $display("FAIL wrap5_end: got wptr=%0d rptr=%0d cnt=%0d want 2 3 4", wptr_s[1],
                     rptr_s[1], count_s[1]);
        end
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 3; k++) cycle(1, 1, 0, 0);
        #2 n_rst = 0;
        #1;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            n_vec++;
            if (got_vec(i) !== RstVec) begin
                n_err++;
                $display("FAIL async_reset[%0d]: got %h want %h", i, got_vec(i), RstVec);
            end
        end
        @(negedge clk);
        n_rst = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            int wr_pct;
            bit wr, rd, fl, clr;
            wr_pct = ((n / 100) % 3 == 0) ? 80 : (((n / 100) % 3 == 1) ? 20 : 50);
            wr  = $urandom_range(0, 99) < wr_pct;
            rd  = $urandom_range(0, 99) < (100 - wr_pct);
            fl  = $urandom_range(0, 39) == 0;
            clr = $urandom_range(0, 29) == 0;
            wr_req = wr; rd_req = rd; flush = fl; clr_err = clr;
            #3;
            for (int i = 0; i < 2; i++) begin
                n_vec++;
                if (wr_en_s[i] !== m_push(i, wr, fl)) begin
                    n_err++;
                    $display("FAIL rnd_wr_en[%0d] @%0d: got %b want %b", i, n, wr_en_s[i],
                             m_push(i, wr, fl));
                end
            end
            @(posedge clk);
            model_step(wr, rd, fl, clr);
            #1;
            for (int i = 0; i < 2; i++) begin
                n_vec++;
                if (got_vec(i) !== exp_vec(i)) begin
                    n_err++;
                    $display("FAIL rnd_state[%0d] @%0d: got %h want %h", i, n, got_vec(i),
                             exp_vec(i));
                end
            end
        end
        wr_req = 0; rd_req = 0; flush = 0; clr_err = 0;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_push_pop_full();
        test_drain();
        test_back_to_back();
        test_flush();
        test_wrap5();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
